// File: rtl/cam_pkg.sv
// Shared types and constants for the camera pixel packing path.
package cam_pkg;
  localparam int PIX_W  = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = 32;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        sof;
  } pix_word_t;

  // Mask with the lowest n lanes set.
  function automatic logic [LANES-1:0] lane_keep(input logic [1:0] n);
    lane_keep = (4'b0001 << n) - 4'b0001;
  endfunction

  // Widen a lane mask to a byte mask over the data word.
  function automatic logic [WORD_W-1:0] keep_bytes(input logic [LANES-1:0] k);
    keep_bytes = {{PIX_W{k[3]}}, {PIX_W{k[2]}}, {PIX_W{k[1]}}, {PIX_W{k[0]}}};
  endfunction
endpackage

// File: rtl/cam_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head shows zero while empty.
module cam_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/pixel_word_packer.sv
// Packs the 8-bit capture stream into 32-bit words with frame-start tags,
// buffering them behind valid/ready and dropping whole words on overflow.
module pixel_word_packer
  import cam_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  input  logic [15:0] frame_count,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_keep,
  output logic        out_sof,
  output logic [15:0] drop_count,
  output logic        overflow
);
  logic [23:0] acc, acc_n;
  logic [1:0]  lane, lane_n;
  logic        sof_flag, sof_n;
  logic [15:0] last_frame;
  logic        accepted, new_frame, push, pop, full, empty, drop;
  pix_word_t   push_word, head;

  assign accepted  = enable && pix_valid;
  assign new_frame = accepted && (frame_count != last_frame);
  assign pop       = out_valid && out_ready;
  assign drop      = push && full && !pop;

  always_comb begin
    push      = 1'b0;
    push_word = '0;
    acc_n     = acc;
    lane_n    = lane;
    sof_n     = sof_flag;
    if (!enable) begin
      acc_n  = '0;
      lane_n = '0;
      sof_n  = 1'b0;
    end else if (pix_valid) begin
      if (new_frame && lane != 2'd0) begin
        // Flush the partial word; the new-frame pixel opens a fresh one.
        push           = 1'b1;
        push_word.keep = lane_keep(lane);
        push_word.data = {8'h00, acc} & keep_bytes(lane_keep(lane));
        push_word.sof  = sof_flag;
        acc_n          = {16'h0000, pix_data};
        lane_n         = 2'd1;
        sof_n          = 1'b1;
      end else if (lane == 2'd3) begin
        push           = 1'b1;
        push_word.keep = 4'b1111;
        push_word.data = {pix_data, acc};
        push_word.sof  = sof_flag;
        acc_n          = '0;
        lane_n         = 2'd0;
        sof_n          = 1'b0;
      end else begin
        case (lane)
          2'd0:    acc_n[7:0]   = pix_data;
          2'd1:    acc_n[15:8]  = pix_data;
          default: acc_n[23:16] = pix_data;
        endcase
        lane_n = lane + 2'd1;
        if (new_frame) sof_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      lane       <= '0;
      sof_flag   <= 1'b0;
      last_frame <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      acc      <= acc_n;
      lane     <= lane_n;
      sof_flag <= sof_n;
      if (accepted) last_frame <= frame_count;
      if (!enable) overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  cam_sync_fifo #(.DEPTH(DEPTH), .W($bits(pix_word_t))) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign out_valid = !empty;
  assign out_data  = head.data;
  assign out_keep  = head.keep;
  assign out_sof   = head.sof;
endmodule

// File: tb/tb_pixel_word_packer.sv
// Directed plus random stimulus against a queue-based reference of the packer.
module tb_pixel_word_packer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, enable, pix_valid, out_ready;
  logic [7:0]  pix_data;
  logic [15:0] frame_count;
  logic        out_valid, out_sof, overflow;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        s;
  } mw_t;

  mw_t         q[$];
  logic [7:0]  pend[$];
  bit          msof;
  logic [15:0] mlast;
  int unsigned mdrop;
  bit          movf;

  pixel_word_packer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pix_valid(pix_valid),
    .pix_data(pix_data), .frame_count(frame_count), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
    .out_sof(out_sof), .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend.delete();
    msof  = 1'b0;
    mlast = '0;
    mdrop = 0;
    movf  = 1'b0;
  endtask

  function automatic mw_t pend_word();
    mw_t w;
    w.d = '0;
    w.k = '0;
    w.s = msof;
    foreach (pend[i]) begin
      w.d[8*i +: 8] = pend[i];
      w.k[i]        = 1'b1;
    end
    return w;
  endfunction

  // Reference: a word is a list of pending pixels; it leaves when it reaches
  // four pixels or a new frame starts, then competes for FIFO space.
  task automatic model_step(input bit en, input bit pv, input logic [7:0] px,
                            input logic [15:0] fc, input bit rdy);
    mw_t w;
    bit  have = 1'b0;
    bit  pop  = (q.size() > 0) && rdy;
    if (!en) begin
      pend.delete();
      msof = 1'b0;
      movf = 1'b0;
    end else if (pv) begin
      bit nf = (fc != mlast);
      mlast = fc;
      if (nf && pend.size() > 0) begin
        w = pend_word();
        have = 1'b1;
        pend.delete();
      end
      if (nf) msof = 1'b1;
      pend.push_back(px);
      if (pend.size() == 4) begin
        w = pend_word();
        have = 1'b1;
        pend.delete();
        msof = 1'b0;
      end
    end
    if (pop) void'(q.pop_front());
    if (have) begin
      if (q.size() < DEPTH) q.push_back(w);
      else begin
        if (mdrop < 16'hFFFF) mdrop++;
        if (en) movf = 1'b1;
      end
    end
  endtask

  task automatic check_outs();
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_keep", {28'b0, out_keep}, {28'b0, q[0].k});
      chk("out_sof", {31'b0, out_sof}, {31'b0, q[0].s});
    end
    chk("drop_count", {16'b0, drop_count}, mdrop);
    chk("overflow", {31'b0, overflow}, {31'b0, movf});
  endtask

  task automatic cyc(input bit en, input bit pv, input logic [7:0] px,
                     input logic [15:0] fc, input bit rdy);
    enable = en; pix_valid = pv; pix_data = px; frame_count = fc; out_ready = rdy;
    model_step(en, pv, px, fc, rdy);
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_keep"}, {28'b0, out_keep}, 32'd0);
    chk({tag, "_sof"}, {31'b0, out_sof}, 32'd0);
    chk({tag, "_drop"}, {16'b0, drop_count}, 32'd0);
    chk({tag, "_ovf"}, {31'b0, overflow}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; pix_valid = 1'b0; pix_data = '0;
    frame_count = '0; out_ready = 1'b0;
    model_reset();
    #12;
    check_reset_outs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Two full words in frame 1; first one carries sof.
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 1, 8'(i), 16'd1, 1);
      if (i == 4) begin
        chk("first_word_latency", {31'b0, out_valid}, 32'd1);
        chk("first_word", out_data, 32'h04030201);
      end
    end
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'h00, 16'd1, 1);

    // Frame change mid-word flushes a two-lane partial.
    for (int i = 0; i < 6; i++) cyc(1, 1, 8'hA0 + 8'(i), 16'd1, 0);
    cyc(1, 1, 8'hB0, 16'd2, 0);
    chk("flush_partial_keep", {28'b0, q[1].k}, 32'h3);
    for (int i = 1; i < 4; i++) cyc(1, 1, 8'hB0 + 8'(i), 16'd2, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'h00, 16'd2, 1);

    // Stalled sink: 6 words offered, 4 held, 2 dropped.
    for (int i = 0; i < 24; i++) cyc(1, 1, 8'h10 + 8'(i), 16'd3, 0);
    chk("stall_drop_count", {16'b0, drop_count}, 32'd2);
    chk("stall_overflow", {31'b0, overflow}, 32'd1);
    // Completing a word while full but popping: no drop.
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'h40 + 8'(i), 16'd3, 0);
    cyc(1, 1, 8'h43, 16'd3, 1);
    chk("full_push_pop_no_drop", {16'b0, drop_count}, 32'd2);
    for (int i = 0; i < 6; i++) cyc(1, 0, 8'h00, 16'd3, 1);

    // Enable low discards a 3-pixel partial and clears overflow.
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'h50 + 8'(i), 16'd3, 1);
    cyc(0, 0, 8'h00, 16'd3, 1);
    chk("enable_low_ovf_clear", {31'b0, overflow}, 32'd0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'h60 + 8'(i), 16'd3, 1);
    chk("after_enable_word", out_data, 32'h63626160);
    chk("after_enable_sof", {31'b0, out_sof}, 32'd0);
    cyc(1, 0, 8'h00, 16'd3, 1);

    // Random traffic with occasional frame changes and enable drops.
    begin
      logic [15:0] fc = 16'd3;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 29) == 0) fc = fc + 16'd1;
        cyc($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0,
            8'($urandom), fc, $urandom_range(0, 2) == 0);
      end
    end
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'h00, frame_count, 1);

    // Asynchronous reset mid-word with a non-empty FIFO.
    for (int i = 0; i < 10; i++) cyc(1, 1, 8'h70 + 8'(i), 16'd9, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_outs("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'h80 + 8'(i), 16'd9, 1);
    chk("post_reset_sof", {31'b0, out_sof}, 32'd1);
    chk("post_reset_word", out_data, 32'h83828180);
    cyc(1, 0, 8'h00, 16'd9, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pixel_word_packer.md
# pixel_word_packer

Downstream of the camera capture stage: consumes its registered 8-bit pixel stream and running frame counter, packs four pixels into 32-bit words, and buffers them in a small FIFO behind a valid/ready interface toward the frame-store writer. Frame starts are detected from frame-counter changes and tagged on the output. Since the input cannot be back-pressured, overflow drops whole words and counts them.

## Interface
- DEPTH, 4: FIFO depth in words; power of two, ≥2
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  block enable; low flushes the packer, FIFO keeps draining
- pix_valid  in  1  pixel strobe from capture stage
- pix_data  in  8  pixel value
- frame_count  in  16  capture frame counter, updated on the same edge as the first pixel of a frame
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accept
- out_data  out  32  packed word; lane 0 = bits[7:0] = earliest pixel
- out_keep  out  4  valid-lane mask; 4'b1111 except flushed partials
- out_sof  out  1  word's lane 0 holds the first pixel of a frame
- drop_count  out  16  words dropped on full FIFO, saturating
- overflow  out  1  sticky drop flag

## Operation
- Accepted pixel: enable && pix_valid. Stored in lane `lane` (0..3) of the accumulator, then lane increments.
- New frame: accepted pixel with frame_count != last_frame; last_frame <= frame_count on every accepted pixel.
- Normal push: accepted pixel at lane 3 pushes {pix_data, acc[23:0]}, keep 4'b1111, sof = stored sof flag; lane -> 0.
- New frame with lane != 0: the partial word is pushed (keep = lanes 0..lane-1 set, unused lanes 0x00, its own sof flag); the new pixel goes to lane 0, lane -> 1, sof flag set. At most one push per cycle.
- New frame with lane == 0: no flush; pixel to lane 0, sof flag set.
- sof flag clears after the word carrying it is pushed or dropped.
- Push acceptance: !full || (out_valid && out_ready); otherwise the word is dropped, drop_count += 1 (saturates at 16'hFFFF), overflow <= 1.
- enable low: lane -> 0, accumulator and sof flag cleared (partial discarded, not pushed), overflow cleared; drop_count and last_frame held; FIFO pops continue.
- Pop: out_valid && out_ready removes head; out_data/out_keep/out_sof show head entry, stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid 0, out_data 0, out_keep 0, out_sof 0, drop_count 0, overflow 0; lane 0, last_frame 0, FIFO empty.
- Latency: word pushed on edge sampling its completing pixel (or the new-frame pixel) -> out_valid high in the following cycle when the FIFO was empty.
- Full throughput: one pixel per cycle sustains one word per 4 cycles; out_ready low for more than 4·DEPTH cycles at full rate overflows.
- Simultaneous push and pop when full: both occur, occupancy unchanged, no drop.
- Simultaneous push and pop when empty: push lands, out_valid rises next cycle (no fall-through).
- Reset mid-frame: all state cleared immediately; first pixel after reset with frame_count != 0 is tagged sof.

## Structure
- Shared package cam_pkg: PIX_W = 8, LANES = 4, WORD_W = 32, typedef struct packed {logic [31:0] data; logic [3:0] keep; logic sof;} pix_word_t.
- Sub-module cam_sync_fifo (parameterised on DEPTH and element type width, pointer + extra wrap bit full/empty); packer logic in the top.

## Test plan
- Reset, frame_count 1, pixels 0x01..0x08 consecutive -> two words 0x04030201 (sof 1) and 0x08070605 (sof 0), keep 4'hF, first out_valid one cycle after 4th pixel.
- 6 pixels 0xA0..0xA5 in frame 1, then frame_count 2 with pixel 0xB0 -> word 0xA3A2A1A0, flushed 0x0000A5A4 keep 4'b0011, then next word starts 0xB0 with sof 1.
- out_ready held 0, DEPTH=4, 24 pixels -> 4 words buffered, 2 dropped, drop_count 2, overflow 1; release -> 4 words in order.
- FIFO full, out_ready 1 on the cycle a word completes -> no drop, occupancy remains 4.
- enable drops after 3 pixels, then rises with 4 pixels of same frame -> partial discarded, one word of the new 4 pixels, sof 0, overflow cleared.
- rst asserted mid-word with FIFO non-empty -> all outputs to reset values in the same cycle; drop_count 0.
